packet_assembler: RTL and testbench

//  Upstream stage of the receive path. Collects bytes strobed out of the laser

---
 rtl/packet_assembler.sv | 100 ++++++++++
 tb/tb_packet_assembler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler.sv
// Frames SYNC-delimited byte strobes into fixed-length packets, with an inter-byte
// timeout that aborts partial packets, and saturating frame/drop counters.
module packet_assembler #(
    parameter int          NBYTES  = 36,
    parameter logic [7:0]  SYNC    = 8'h7E,
    parameter logic [19:0] TIMEOUT = 20'd650000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic [8*NBYTES-1:0]   packet,
    output logic                  ready,
    output logic                  busy,
    output logic [7:0]            frame_count,
    output logic [7:0]            drop_count
);

    localparam int            IW        = $clog2(NBYTES);
    localparam int            SW        = 8*NBYTES - 8;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
    localparam logic [19:0]   GAP_LIMIT = TIMEOUT - 20'd1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx;
    logic [19:0]   gap;
    logic [SW-1:0] shreg;
    logic          start, take, finish, abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A strobe in COLLECT always wins over the timeout check.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        take       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (byte_valid && byte_in == SYNC) begin
                    start      = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    take = 1'b1;
                    if (idx == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end else if (gap == GAP_LIMIT) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            gap         <= '0;
            shreg       <= '0;
            packet      <= '0;
            ready       <= 1'b0;
            frame_count <= 8'd0;
            drop_count  <= 8'd0;
        end else begin
            ready <= finish;
            if (start)
                idx <= '0;
            else if (take)
                idx <= idx + 1'b1;
            if (start || take || abort)
                gap <= '0;
            else if (state == COLLECT)
                gap <= gap + 20'd1;
            if (take)
                shreg <= {shreg[SW-9:0], byte_in};
            // packet only moves on the final byte, so it holds between frames
            if (finish)
                packet <= {shreg, byte_in};
            if (finish && frame_count != 8'hFF)
                frame_count <= frame_count + 8'd1;
            if (abort && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: expected packets are queued as frames are
// driven and popped by a monitor whenever ready pulses.
`timescale 1ns/1ps
module tb_packet_assembler;

    logic         clk;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic [287:0] packet;
    logic         ready;
    logic         busy;
    logic [7:0]   frame_count;
    logic [7:0]   drop_count;

    int           tests_run;
    int           tests_failed;
    int           ready_seen;
    logic [287:0] exp_q[$];

    packet_assembler #(
        .NBYTES (36),
        .SYNC   (8'h7E),
        .TIMEOUT(20'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .packet     (packet),
        .ready      (ready),
        .busy       (busy),
        .frame_count(frame_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t required < 5ms", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && ready) begin
            ready_seen++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_ready: ready=1 with empty scoreboard, packet=%h", packet);
            end else begin
                logic [287:0] e;
                e = exp_q.pop_front();
                if (packet !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL scoreboard_packet: got %h expected %h", packet, e);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [287:0] data, input int gap);
        send_byte(8'h7E, gap);
        for (int i = 0; i < 36; i++) begin
            if (i == 35) exp_q.push_back(data);
            send_byte(data[287 - 8*i -: 8], gap);
        end
    endtask

    function automatic logic [287:0] rand_pkt();
        logic [287:0] p;
        for (int i = 0; i < 9; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_drained: %0d packets outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        #12;
        tests_run++;
        if (packet !== 288'd0 || ready !== 1'b0 || busy !== 1'b0 ||
            frame_count !== 8'd0 || drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: ready=%b busy=%b fc=%0d dc=%0d pkt=%h, expected all zero",
                     ready, busy, frame_count, drop_count, packet);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [287:0] d;
        int r0;
        do_reset();
        for (int i = 0; i < 36; i++) d[287 - 8*i -: 8] = 8'(i);
        r0 = ready_seen;
        send_byte(8'h7E, 10);
        for (int i = 0; i < 35; i++) send_byte(8'(i), 10);
        exp_q.push_back(d);
        byte_in    = 8'h23;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: ready=%b one cycle after last byte, expected 1", ready);
        end
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_pulse_width: ready=%b second cycle, expected 0", ready);
        end
        tests_run++;
        if (packet[287:280] !== 8'h00 || packet[7:0] !== 8'h23) begin
            tests_failed++;
            $display("[TB] FAIL basic_bytes: first=%h last=%h, expected 00 and 23", packet[287:280], packet[7:0]);
        end
        tests_run++;
        if (frame_count !== 8'd1 || busy !== 1'b0 || ready_seen - r0 != 1) begin
            tests_failed++;
            $display("[TB] FAIL basic_status: fc=%0d busy=%b pulses=%0d, expected 1 0 1",
                     frame_count, busy, ready_seen - r0);
        end
        check_drained("basic");
    endtask

    task automatic test_garbage();
        do_reset();
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_frame({36{8'hA5}}, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (packet !== {36{8'hA5}} || frame_count !== 8'd1 || drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL garbage: fc=%0d dc=%0d pkt=%h, expected 1 0 all-A5", frame_count, drop_count, packet);
        end
        check_drained("garbage");
    endtask

    task automatic test_timeout();
        logic [287:0] p, q;
        do_reset();
        p = rand_pkt();
        q = rand_pkt();
        send_frame(p, 0);
        send_byte(8'h7E, 0);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 0);
        repeat (99) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early: busy=%b dc=%0d after 99 idle, expected 1 0", busy, drop_count);
        end
        send_byte(8'h11, 0);
        tests_run++;
        if (busy !== 1'b1 || drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_byte_wins: busy=%b dc=%0d, expected 1 0", busy, drop_count);
        end
        repeat (99) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_gap_cleared: busy=%b after 99 idle, expected 1", busy);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || drop_count !== 8'd1 || packet !== p || ready_seen == 0 && 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_abort: busy=%b dc=%0d pkt=%h, expected 0 1 %h", busy, drop_count, packet, p);
        end
        send_frame(q, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (packet !== q || frame_count !== 8'd2 || drop_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_recover: fc=%0d dc=%0d pkt=%h, expected 2 1 %h", frame_count, drop_count, packet, q);
        end
        check_drained("timeout");
    endtask

    task automatic test_back_to_back();
        logic [287:0] a, b;
        int r0;
        do_reset();
        a  = rand_pkt();
        b  = rand_pkt();
        r0 = ready_seen;
        send_frame(a, 0);
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready_cycle: ready=%b when next SYNC driven, expected 1", ready);
        end
        send_frame(b, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (packet !== b || frame_count !== 8'd2 || ready_seen - r0 != 2) begin
            tests_failed++;
            $display("[TB] FAIL b2b: fc=%0d pulses=%0d pkt=%h, expected 2 2 %h", frame_count, ready_seen - r0, packet, b);
        end
        check_drained("b2b");
    endtask

    task automatic test_sync_in_payload();
        logic [287:0] d;
        int r0;
        do_reset();
        for (int i = 0; i < 36; i++) d[287 - 8*i -: 8] = 8'(i + 1);
        d[247:240] = 8'h7E;
        r0 = ready_seen;
        send_frame(d, 1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (packet[247:240] !== 8'h7E || ready_seen - r0 != 1 || frame_count !== 8'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sync_payload: byte5=%h pulses=%0d fc=%0d busy=%b, expected 7E 1 1 0",
                     packet[247:240], ready_seen - r0, frame_count, busy);
        end
        check_drained("sync_payload");
    endtask

    task automatic test_reset_midpacket();
        logic [287:0] f, g;
        int r0;
        do_reset();
        f = rand_pkt();
        g = rand_pkt();
        send_frame(f, 2);
        send_byte(8'h7E, 0);
        for (int i = 0; i < 20; i++) send_byte(8'(8'h90 + i), 0);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (packet !== 288'd0 || ready !== 1'b0 || busy !== 1'b0 ||
            frame_count !== 8'd0 || drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: ready=%b busy=%b fc=%0d dc=%0d pkt=%h, expected all zero",
                     ready, busy, frame_count, drop_count, packet);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        r0 = ready_seen;
        send_frame(g, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (packet !== g || frame_count !== 8'd1 || drop_count !== 8'd0 || ready_seen - r0 != 1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_recover: fc=%0d dc=%0d pulses=%0d pkt=%h, expected 1 0 1 %h",
                     frame_count, drop_count, ready_seen - r0, packet, g);
        end
        check_drained("midreset");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 255; n++) send_frame(rand_pkt(), 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (frame_count !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL frame_count_255: got %0d expected 255", frame_count);
        end
        send_frame(rand_pkt(), 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (frame_count !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL frame_count_sat: got %0d expected 255", frame_count);
        end
        for (int n = 0; n < 256; n++) begin
            send_byte(8'h7E, 0);
            send_byte(8'h01, 100);
        end
        tests_run++;
        if (drop_count !== 8'd255 || busy !== 1'b0 || frame_count !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL drop_count_sat: dc=%0d busy=%b fc=%0d, expected 255 0 255", drop_count, busy, frame_count);
        end
        check_drained("saturation");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ready_seen   = 0;
        test_reset();
        test_basic();
        test_garbage();
        test_timeout();
        test_back_to_back();
        test_sync_in_payload();
        test_reset_midpacket();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
